// File: rtl/tetris_input_conditioner.sv
// Push-button front end for the Tetris controller: sync, debounce, optional auto-repeat
// (define AUTO_REPEAT_EN) and pending command registers held until the game tick consumes them.
module tetris_input_conditioner #(
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 15000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       btn_down,
  input  logic       btn_rotate,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       game_tick,
  output logic       cmd_down,
  output logic       cmd_rotate,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic [3:0] btn_state
);

  // Bit order everywhere: {down, rotate, left, right}
  localparam logic [3:0]       Released = {4{BTN_ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       w_raw;
  logic [3:0]       w_sync;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_state;
  logic [3:0]       r_state_dly;
  logic [3:0]       r_press;
  logic [CNT_W-1:0] r_dcnt [4];
  logic [3:0]       w_press_ev;
  logic [3:0]       w_ev;
  logic [3:0]       w_cmd_base;
  logic [3:0]       w_cmd_d;
  logic [3:0]       r_cmd;

  assign w_raw  = {btn_down, btn_rotate, btn_left, btn_right};
  assign w_sync = BTN_ACTIVE_LOW ? ~r_sync2 : r_sync2;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= Released;
      r_sync2 <= Released;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Counter tracks consecutive cycles the synced level disagrees with the accepted one
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= '0;
      for (int i = 0; i < 4; i++) begin
        r_dcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_sync[i] == r_state[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DebLast) begin
          r_dcnt[i]  <= '0;
          r_state[i] <= ~r_state[i];
        end else begin
          r_dcnt[i] <= r_dcnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state_dly <= '0;
      r_press     <= '0;
    end else begin
      r_state_dly <= r_state;
      r_press     <= r_state & ~r_state_dly;
    end
  end

  assign w_press_ev = r_press & r_state;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

  logic [2:0] w_rep_ev;

  for (genvar g = 0; g < 3; g++) begin : g_rep
    // Repeat slots 0,1,2 serve right, left, down
    localparam int unsigned Idx = (g == 2) ? 3 : g;

    rep_state_e       r_rst;
    logic [CNT_W-1:0] r_rcnt;

    always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
        r_rst  <= StIdle;
        r_rcnt <= '0;
      end else if (!r_state[Idx]) begin
        r_rst  <= StIdle;
        r_rcnt <= '0;
      end else begin
        unique case (r_rst)
          StIdle: begin
            if (r_press[Idx]) begin
              r_rst  <= StDelay;
              r_rcnt <= '0;
            end
          end
          StDelay: begin
            if (r_rcnt == DelayLast) begin
              r_rst  <= StRepeat;
              r_rcnt <= '0;
            end else begin
              r_rcnt <= r_rcnt + CNT_W'(1);
            end
          end
          StRepeat: begin
            if (r_rcnt == RateLast) begin
              r_rcnt <= '0;
            end else begin
              r_rcnt <= r_rcnt + CNT_W'(1);
            end
          end
          default: begin
            r_rst  <= StIdle;
            r_rcnt <= '0;
          end
        endcase
      end
    end

    // Release wins over a terminal count: no event while the button reads released
    assign w_rep_ev[g] = r_state[Idx] &
                         (((r_rst == StIdle)   & r_press[Idx]) |
                          ((r_rst == StDelay)  & (r_rcnt == DelayLast)) |
                          ((r_rst == StRepeat) & (r_rcnt == RateLast)));
  end

  assign w_ev = {w_rep_ev[2], w_press_ev[2], w_rep_ev[1], w_rep_ev[0]};
`else
  logic w_unused_repeat_params;
  assign w_unused_repeat_params = ^{REPEAT_DELAY, REPEAT_RATE};
  assign w_ev = w_press_ev;
`endif

  // A tick consumes the current commands but keeps events landing in the same cycle
  always_comb begin
    w_cmd_base = game_tick ? 4'b0000 : r_cmd;
    w_cmd_d[3] = w_cmd_base[3] | w_ev[3];
    w_cmd_d[2] = w_cmd_base[2] | w_ev[2];
    w_cmd_d[1] = (w_cmd_base[1] | w_ev[1]) & ~w_ev[0];
    w_cmd_d[0] = (w_cmd_base[0] | w_ev[0]) & ~w_ev[1];
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd <= '0;
    end else begin
      r_cmd <= w_cmd_d;
    end
  end

  assign cmd_down   = r_cmd[3];
  assign cmd_rotate = r_cmd[2];
  assign cmd_left   = r_cmd[1];
  assign cmd_right  = r_cmd[0];
  assign btn_state  = r_state;

endmodule

// File: tb/tb_tetris_input_conditioner.sv
// Randomised and directed bench for tetris_input_conditioner against an in-bench behavioural model.
module tb_tetris_input_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 8;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] tb_raw = 4'hF;
  logic       game_tick = 1'b0;
  logic       cmd_down, cmd_rotate, cmd_left, cmd_right;
  logic [3:0] btn_state;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  checking = 1'b0;
  bit  tick_auto = 1'b1;
  bit  tick_rand = 1'b0;
  int  tick_period = 50;

  tetris_input_conditioner #(
    .BTN_ACTIVE_LOW (1'b1),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (32)
  ) dut (
    .clk_50    (clk),
    .reset_n   (reset_n),
    .btn_down  (tb_raw[3]),
    .btn_rotate(tb_raw[2]),
    .btn_left  (tb_raw[1]),
    .btn_right (tb_raw[0]),
    .game_tick (game_tick),
    .cmd_down  (cmd_down),
    .cmd_rotate(cmd_rotate),
    .cmd_left  (cmd_left),
    .cmd_right (cmd_right),
    .btn_state (btn_state)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: values the DUT registers should hold after each edge
  logic [3:0] m_s1, m_s2, m_state, m_state_prev, m_press, m_ev, m_cmd;
  logic [3:0] m_hist [DEB];
  int         m_n [4];
  bit         m_act [4];

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF;
    m_state = '0; m_state_prev = '0; m_press = '0; m_ev = '0; m_cmd = '0;
    for (int k = 0; k < DEB; k++) m_hist[k] = '0;
    for (int i = 0; i < 4; i++) begin
      m_n[i] = 0;
      m_act[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [3:0] sync;
    logic [3:0] old_state;
    bit         all_diff;
    // pending commands from last cycle's events
    if (game_tick) m_cmd = '0;
    if (m_ev[1] && m_ev[0]) begin
      m_cmd[1] = 1'b0; m_cmd[0] = 1'b0;
    end else if (m_ev[1]) begin
      m_cmd[1] = 1'b1; m_cmd[0] = 1'b0;
    end else if (m_ev[0]) begin
      m_cmd[0] = 1'b1; m_cmd[1] = 1'b0;
    end
    m_cmd[3] = m_cmd[3] | m_ev[3];
    m_cmd[2] = m_cmd[2] | m_ev[2];
    m_press = m_state & ~m_state_prev;
    // accept a level once the last DEB synced samples all disagree with the current one
    sync = ~m_s2;
    for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = sync;
    old_state = m_state;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) if (m_hist[k][i] == old_state[i]) all_diff = 1'b0;
      if (all_diff) m_state[i] = ~old_state[i];
    end
    m_state_prev = old_state;
    m_s2 = m_s1;
    m_s1 = tb_raw;
    // events: press, then RD cycles later, then every RR while held
    for (int i = 0; i < 4; i++) begin
      if (!m_state[i]) begin
        m_act[i] = 1'b0;
        m_ev[i] = 1'b0;
      end else if (m_press[i]) begin
        m_act[i] = 1'b1;
        m_n[i] = 0;
        m_ev[i] = 1'b1;
      end else if (m_act[i] && AUTO && i != 2) begin
        m_n[i]++;
        m_ev[i] = (m_n[i] == RD) || (m_n[i] > RD && ((m_n[i] - RD) % RR) == 0);
      end else begin
        m_ev[i] = 1'b0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  always @(negedge clk) begin
    if (checking && reset_n) begin
      check("btn_state", {28'd0, btn_state}, {28'd0, m_state});
      check("cmd", {28'd0, cmd_down, cmd_rotate, cmd_left, cmd_right}, {28'd0, m_cmd});
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tick_auto) game_tick = tick_rand ? ($urandom_range(0, 7) == 0) : ((cyc % tick_period) == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t0, t_rise, rises;
    logic prev;
    int got[$];
    int exp_off[$];

    idle(3);
    reset_n = 1'b1;
    checking = 1'b1;

    // 1: idle buttons
    idle(200);
    check("idle_state", {28'd0, btn_state}, 32'd0);
    check("idle_cmd", {28'd0, cmd_down, cmd_rotate, cmd_left, cmd_right}, 32'd0);

    // 2: bouncing rotate, then stable press
    for (int k = 0; k < 10; k++) begin
      tb_raw[2] = (k % 2 == 0) ? 1'b0 : 1'b1;
      idle(2);
    end
    tb_raw[2] = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 50 && !btn_state[2]; k++) @(negedge clk);
    check("rot_state_lat", cyc - t0, 6);
    for (int k = 0; k < 50 && !cmd_rotate; k++) @(negedge clk);
    check("rot_cmd_lat", cyc - t0, 8);
    for (int k = 0; k < 60 && cmd_rotate; k++) @(negedge clk);
    check("rot_cleared", {31'd0, cmd_rotate}, 32'd0);
    check("rot_clear_tick", cyc % 50, 1);
    tb_raw[2] = 1'b1;
    idle(20);

    // 3: hold left with no tick
    tick_auto = 1'b0;
    game_tick = 1'b0;
    idle(1);
    tb_raw[1] = 1'b0;
    rises = 0;
    prev = cmd_left;
    for (int k = 0; k < 100; k++) begin
      idle(1);
      if (cmd_left && !prev) rises++;
      prev = cmd_left;
    end
    check("left_rises", rises, 1);
    check("left_held", {31'd0, cmd_left}, 32'd1);
    game_tick = 1'b1;
    idle(1);
    game_tick = 1'b0;
    idle(30);
    tb_raw[1] = 1'b1;
    idle(20);

    // 4: down with a tick every cycle
    tick_period = 1;
    tick_auto = 1'b1;
    tb_raw[3] = 1'b0;
    t_rise = -1;
    for (int k = 0; k < 150; k++) begin
      idle(1);
      if (t_rise < 0 && btn_state[3]) t_rise = cyc;
      if (t_rise >= 0 && cmd_down) got.push_back(cyc - t_rise);
      if (t_rise >= 0 && cyc - t_rise == 50) tb_raw[3] = 1'b1;
    end
    if (AUTO) exp_off = '{2, 22, 30, 38, 46, 54};
    else exp_off = '{2};
    check("down_ev_count", got.size(), exp_off.size());
    for (int k = 0; k < exp_off.size() && k < got.size(); k++) check("down_ev_off", got[k], exp_off[k]);
    idle(20);

    // 5: left then right before a tick; then both together
    tick_auto = 1'b0;
    game_tick = 1'b0;
    idle(1);
    tb_raw[1] = 1'b0;
    idle(10);
    tb_raw[0] = 1'b0;
    idle(12);
    game_tick = 1'b1;
    check("lr_left", {31'd0, cmd_left}, 32'd0);
    check("lr_right", {31'd0, cmd_right}, 32'd1);
    idle(1);
    game_tick = 1'b0;
    tb_raw[1:0] = 2'b11;
    idle(20);
    tb_raw[1:0] = 2'b00;
    idle(30);
    check("both_left", {31'd0, cmd_left}, 32'd0);
    check("both_right", {31'd0, cmd_right}, 32'd0);
    tb_raw[1:0] = 2'b11;
    idle(20);

    // 6: reset in the middle of a held press
    tb_raw[3] = 1'b0;
    for (int k = 0; k < 30 && !cmd_down; k++) @(negedge clk);
    check("rst_pre_cmd", {31'd0, cmd_down}, 32'd1);
    idle(8);
    reset_n = 1'b0;
    #1;
    check("rst_state", {28'd0, btn_state}, 32'd0);
    check("rst_cmd", {28'd0, cmd_down, cmd_rotate, cmd_left, cmd_right}, 32'd0);
    idle(2);
    reset_n = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 30 && !cmd_down; k++) @(negedge clk);
    check("rst_repress_lat", cyc - t0, 8);
    tb_raw[3] = 1'b1;
    idle(20);

    // random traffic
    tick_rand = 1'b1;
    tick_auto = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 29) == 0) tb_raw[i] = ~tb_raw[i];
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
      end
      idle(1);
    end

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
